// File: rtl/data_path_pkg.sv
// Shared types for the 8-bit multicycle datapath and its controller:
// ALU opcodes, operand/next-PC select encodings and the instruction layout.
package data_path_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned IW   = 32;
  localparam int unsigned NREG = 8;
  localparam int unsigned RAW  = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_PASS = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG = 2'd0,
    SRCB_ONE = 2'd1,
    SRCB_IMM = 2'd2,
    SRCB_BR  = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_ALU2   = 2'd3
  } pcsrc_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

endpackage

// File: rtl/data_path_alu8.sv
// 8-bit ALU: operation decode, result and zero flag.
module alu8
  import data_path_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result_c,
  output logic          zero_c
);

  always_comb begin
    result_c = '0;
    case (alu_op_e'(op))
      ALU_ADD:  result_c = a + b;
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_NOR:  result_c = ~(a | b);
      ALU_XOR:  result_c = a ^ b;
      ALU_PASS: result_c = b;
      ALU_SUB:  result_c = a - b;
      ALU_SLT:  result_c = ($signed(a) < $signed(b)) ? DW'(1) : '0;
      default:  result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/data_path.sv
// Multicycle MIPS-subset datapath: PC, IR, MDR, A/B, ALUOut, 8x8 register
// file, ALU and steering muxes; every select comes from the controller.
module data_path
  import data_path_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] memdata,
  input  logic          alusrca,
  input  logic [1:0]    alusrcb,
  input  logic [2:0]    alucontrol,
  input  logic          iord,
  input  logic          memtoreg,
  input  logic          regdst,
  input  logic          regwrite,
  input  logic          pcen,
  input  logic [1:0]    pcsrc,
  input  logic [3:0]    irwrite,
  input  logic          memwrite,
  output logic          zero,
  output logic [IW-1:0] instr,
  output logic [DW-1:0] adr,
  output logic [DW-1:0] writedata,
  output logic [DW-1:0] Reg1Adr,
  output logic [DW-1:0] Reg2Adr,
  output logic          branch,
  output logic [DW-1:0] src1,
  output logic [DW-1:0] src2,
  output logic [DW-1:0] alucheck,
  output logic [DW-1:0] pcvalue,
  output logic [DW-1:0] nextpcvalue,
  output logic [DW-1:0] read1,
  output logic [DW-1:0] read2
);

  instr_t        ir;
  logic [DW-1:0] pc, mdr, a_q, b_q, aluout;
  logic [DW-1:0] rf [NREG];
  logic [RAW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] br_off;

  // Memory writes are issued by the controller directly; nothing to do here.
  logic unused_memwrite;
  assign unused_memwrite = memwrite;

  assign br_off = {ir.funct, 2'b00};
  assign wa     = regdst ? ir.rd[RAW-1:0] : ir.rt[RAW-1:0];
  assign wd     = memtoreg ? mdr : aluout;

  // Register 0 is hardwired to zero on read; it is never written either.
  assign read1 = (ir.rs[RAW-1:0] == '0) ? '0 : rf[ir.rs[RAW-1:0]];
  assign read2 = (ir.rt[RAW-1:0] == '0) ? '0 : rf[ir.rt[RAW-1:0]];

  assign src1 = alusrca ? a_q : pc;

  always_comb begin
    src2 = b_q;
    case (srcb_e'(alusrcb))
      SRCB_REG: src2 = b_q;
      SRCB_ONE: src2 = DW'(1);
      SRCB_IMM: src2 = {ir.shamt[1:0], ir.funct};
      default:  src2 = br_off;
    endcase
  end

  alu8 u_alu (
    .a        (src1),
    .b        (src2),
    .op       (alucontrol),
    .result_c (alucheck),
    .zero_c   (zero)
  );

  always_comb begin
    nextpcvalue = alucheck;
    case (pcsrc_e'(pcsrc))
      PCSRC_ALUOUT: nextpcvalue = aluout;
      PCSRC_JUMP:   nextpcvalue = br_off;
      default:      nextpcvalue = alucheck;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      ir     <= '0;
      mdr    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      mdr    <= memdata;
      a_q    <= read1;
      b_q    <= read2;
      aluout <= alucheck;
      if (pcen) pc <= nextpcvalue;
      for (int i = 0; i < 4; i++) begin
        if (irwrite[i]) ir[8*i +: 8] <= memdata;
      end
      if (regwrite && (wa != '0)) rf[wa] <= wd;
    end
  end

  assign instr     = ir;
  assign pcvalue   = pc;
  assign writedata = b_q;
  assign adr       = iord ? aluout : pc;
  assign Reg1Adr   = {3'b000, ir.rs};
  assign Reg2Adr   = {3'b000, ir.rt};
  assign branch    = pcen & (pcsrc == 2'b01);

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed walk through fetch/branch/write/ALU cases,
// then randomized cycles, all checked against an architectural-state model.
module tb_data_path;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  memdata;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  alucontrol;
  logic        iord, memtoreg, regdst, regwrite, pcen, memwrite;
  logic [1:0]  pcsrc;
  logic [3:0]  irwrite;
  logic        zero, branch;
  logic [31:0] instr;
  logic [7:0]  adr, writedata, Reg1Adr, Reg2Adr, src1, src2, alucheck;
  logic [7:0]  pcvalue, nextpcvalue, read1, read2;

  int total, bad;

  logic [7:0]  m_pc, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_instr;
  logic [7:0]  m_rf [8];
  logic [7:0]  e_r1, e_r2, e_s1, e_s2, e_alu, e_npc;
  logic [7:0]  fetch_bytes [4];
  logic [7:0]  alu_bytes [4];

  always #5 clk = ~clk;

  data_path dut (
    .clk(clk), .reset(reset), .memdata(memdata), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .pcen(pcen),
    .pcsrc(pcsrc), .irwrite(irwrite), .memwrite(memwrite), .zero(zero),
    .instr(instr), .adr(adr), .writedata(writedata), .Reg1Adr(Reg1Adr),
    .Reg2Adr(Reg2Adr), .branch(branch), .src1(src1), .src2(src2),
    .alucheck(alucheck), .pcvalue(pcvalue), .nextpcvalue(nextpcvalue),
    .read1(read1), .read2(read2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [7:0] x);
    return (x > 8'd127) ? int'(x) - 256 : int'(x);
  endfunction

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    int r;
    case (op)
      3'd0: r = int'(x) + int'(y);
      3'd1: r = int'(x & y);
      3'd2: r = int'(x | y);
      3'd3: r = int'(~(x | y));
      3'd4: r = int'(x ^ y);
      3'd5: r = int'(y);
      3'd6: r = int'(x) - int'(y) + 256;
      default: r = (sval(x) < sval(y)) ? 1 : 0;
    endcase
    return 8'(r % 256);
  endfunction

  function automatic logic [7:0] rf_read(input logic [2:0] idx);
    return (idx == 3'd0) ? 8'h00 : m_rf[idx];
  endfunction

  task automatic model_clear();
    m_pc = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_instr = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
  endtask

  task automatic idle();
    reset = 1; memdata = 0; alusrca = 0; alusrcb = 0; alucontrol = 0;
    iord = 0; memtoreg = 0; regdst = 0; regwrite = 0; pcen = 0;
    pcsrc = 0; irwrite = 0; memwrite = 0;
  endtask

  task automatic eval_model();
    e_r1 = rf_read(m_instr[23:21]);
    e_r2 = rf_read(m_instr[18:16]);
    e_s1 = alusrca ? m_a : m_pc;
    case (alusrcb)
      2'd0: e_s2 = m_b;
      2'd1: e_s2 = 8'h01;
      2'd2: e_s2 = m_instr[7:0];
      default: e_s2 = {m_instr[5:0], 2'b00};
    endcase
    e_alu = alu_ref(alucontrol, e_s1, e_s2);
    if (pcsrc == 2'd1)      e_npc = m_aluout;
    else if (pcsrc == 2'd2) e_npc = {m_instr[5:0], 2'b00};
    else                    e_npc = e_alu;
  endtask

  task automatic check_comb();
    eval_model();
    chk("zero", 32'(zero), 32'(e_alu == 8'h00));
    chk("instr", instr, m_instr);
    chk("adr", 32'(adr), 32'(iord ? m_aluout : m_pc));
    chk("writedata", 32'(writedata), 32'(m_b));
    chk("reg1adr", 32'(Reg1Adr), 32'(m_instr[25:21]));
    chk("reg2adr", 32'(Reg2Adr), 32'(m_instr[20:16]));
    chk("branch", 32'(branch), 32'(pcen && pcsrc == 2'd1));
    chk("src1", 32'(src1), 32'(e_s1));
    chk("src2", 32'(src2), 32'(e_s2));
    chk("alucheck", 32'(alucheck), 32'(e_alu));
    chk("pcvalue", 32'(pcvalue), 32'(m_pc));
    chk("nextpc", 32'(nextpcvalue), 32'(e_npc));
    chk("read1", 32'(read1), 32'(e_r1));
    chk("read2", 32'(read2), 32'(e_r2));
  endtask

  // One clock: check settled outputs, advance the model across the edge.
  task automatic step();
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic [31:0] ni;
    #1;
    check_comb();
    wa = regdst ? m_instr[13:11] : m_instr[18:16];
    wd = memtoreg ? m_mdr : m_aluout;
    ni = m_instr;
    for (int i = 0; i < 4; i++) if (irwrite[i]) ni[8*i +: 8] = memdata;
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      if (regwrite && wa != 3'd0) m_rf[wa] = wd;
      if (pcen) m_pc = e_npc;
      m_mdr = memdata; m_a = e_r1; m_b = e_r2; m_aluout = e_alu; m_instr = ni;
    end
    #1;
    chk("pc_reg", 32'(pcvalue), 32'(m_pc));
    chk("instr_reg", instr, m_instr);
    chk("b_reg", 32'(writedata), 32'(m_b));
  endtask

  initial begin
    total = 0; bad = 0;
    fetch_bytes[0] = 8'h20; fetch_bytes[1] = 8'h20;
    fetch_bytes[2] = 8'h85; fetch_bytes[3] = 8'h00;
    alu_bytes[0] = 8'h00; alu_bytes[1] = 8'h08;
    alu_bytes[2] = 8'h22; alu_bytes[3] = 8'h00;
    idle();
    reset = 0;
    model_clear();
    #2;
    chk("rst_pc", 32'(pcvalue), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_read1", 32'(read1), 32'h0);
    chk("rst_read2", 32'(read2), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    @(posedge clk); #1;
    reset = 1;

    // Fetch 0x00852020 a byte at a time while the ALU computes PC+1
    for (int i = 0; i < 4; i++) begin
      irwrite = 4'(1 << i); memdata = fetch_bytes[i]; alusrcb = 2'd1;
      #1 chk("fetch_inc", 32'(alucheck), 32'h01);
      step();
    end
    irwrite = 0;
    #1;
    chk("fetch_instr", instr, 32'h00852020);
    chk("fetch_rs", 32'(Reg1Adr), 32'h4);
    chk("fetch_rt", 32'(Reg2Adr), 32'h5);
    chk("fetch_pc", 32'(pcvalue), 32'h0);

    alusrca = 0; alusrcb = 2'd3; alucontrol = 3'd0;
    #1 chk("brt_src2", 32'(src2), 32'h80);
    chk("brt_alu", 32'(alucheck), 32'h80);
    step();

    alusrca = 1; alusrcb = 2'd0; alucontrol = 3'd6; pcsrc = 2'd1; pcen = 1;
    #1 chk("br_zero", 32'(zero), 32'h1);
    chk("br_branch", 32'(branch), 32'h1);
    chk("br_npc", 32'(nextpcvalue), 32'h80);
    step();
    chk("br_pc", 32'(pcvalue), 32'h80);

    // Write MDR into rd (=4, same as rs) and read it back
    idle(); memdata = 8'h5A;
    step();
    regwrite = 1; regdst = 1; memtoreg = 1;
    step();
    regwrite = 0;
    #1 chk("rd_write", 32'(read1), 32'h5A);

    // All-zero instruction via four simultaneous byte enables; write r0
    irwrite = 4'hF; memdata = 8'h00;
    step();
    irwrite = 0; memdata = 8'h77;
    step();
    regwrite = 1; regdst = 1; memtoreg = 1;
    step();
    regwrite = 0;
    #1 chk("r0_read", 32'(read1), 32'h0);

    // rs=1, rt=2, rd=1: load r1=3, r2=5 then SUB and SLT
    for (int i = 0; i < 4; i++) begin
      irwrite = 4'(1 << i); memdata = alu_bytes[i];
      step();
    end
    irwrite = 0; memdata = 8'h03;
    step();
    regwrite = 1; regdst = 1; memtoreg = 1; memdata = 8'h05;
    step();
    regdst = 0;
    step();
    regwrite = 0;
    step();
    alusrca = 1; alusrcb = 2'd0; alucontrol = 3'd6;
    #1 chk("sub_res", 32'(alucheck), 32'hFE);
    chk("sub_zero", 32'(zero), 32'h0);
    memdata = 8'h01;
    step();
    regwrite = 1; regdst = 1; memtoreg = 0;
    step();
    regdst = 0; memtoreg = 1;
    step();
    regwrite = 0;
    step();
    alucontrol = 3'd7;
    #1 chk("slt_res", 32'(alucheck), 32'h01);
    step();

    // Asynchronous reset in the middle of a cycle with enables active
    pcen = 1; pcsrc = 2'd2; irwrite = 4'hF; memdata = 8'hAB; regwrite = 1;
    #1 reset = 0;
    #1 chk("async_pc", 32'(pcvalue), 32'h0);
    chk("async_instr", instr, 32'h0);
    model_clear();
    step();
    reset = 1;

    repeat (400) begin
      memdata    = 8'($urandom);
      alusrca    = 1'($urandom);
      alusrcb    = 2'($urandom);
      alucontrol = 3'($urandom);
      iord       = 1'($urandom);
      memtoreg   = 1'($urandom);
      regdst     = 1'($urandom);
      regwrite   = 1'($urandom);
      pcen       = 1'($urandom);
      pcsrc      = 2'($urandom);
      irwrite    = 4'($urandom);
      memwrite   = 1'($urandom);
      reset      = 1;
      if ($urandom_range(0, 39) == 0) begin
        reset = 0;
        #1 chk("rand_rst_pc", 32'(pcvalue), 32'h0);
        model_clear();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
